// File: rtl/sb_regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package sb_regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int NRD_DEFAULT  = 2;

    // Width needed to count from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sb_hazard.sv
// Issue hazard check: a source or destination register with an unresolved
// pending write blocks issue, unless this cycle's writeback resolves it.
module sb_hazard #(
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int AW     = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic [NREG-1:0]   busy,
    input  logic [NRD*AW-1:0] iss_rs,
    input  logic [AW-1:0]     iss_rd,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    output logic              ready
);

    logic [NREG-1:0] haz;

    // NOTE: every signal driven here gets a value before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        haz = busy;
        if (BYPASS && we) haz[wa] = 1'b0;
        ready = !haz[iss_rd];
        for (int i = 0; i < NRD; i++) begin
            if (haz[iss_rs[i*AW +: AW]]) ready = 1'b0;
        end
    end

endmodule

// File: rtl/sb_regfile.sv
// Multi-port register file with per-register pending-write scoreboard,
// optional writeback bypass and optional hardwired-zero register 0.
module sb_regfile
    import sb_regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  NREG     = NREG_DEFAULT,
    parameter int  NRD      = NRD_DEFAULT,
    parameter bit  ZERO_REG = 1'b1,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = $clog2(NREG),
    localparam int CW       = cnt_width(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NRD*AW-1:0] iss_rs,
    output logic              iss_ready,
    input  logic              flush,
    output logic [NREG-1:0]   busy,
    output logic [CW-1:0]     pending
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   pending_nxt;
    logic            hazard_free;
    logic            issue;
    logic            wr_en;
    logic            set_en;
    logic            clr_hit;

    sb_hazard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_hazard (
        .busy   (busy),
        .iss_rs (iss_rs),
        .iss_rd (iss_rd),
        .we     (we),
        .wa     (wa),
        .ready  (hazard_free)
    );

    assign iss_ready = hazard_free && !flush;
    assign issue     = iss_valid && iss_ready;
    assign wr_en     = we && !(ZERO_REG && wa == '0);
    assign set_en    = issue && !(ZERO_REG && iss_rd == '0);
    // A same-register issue keeps the bit set, so inc and dec cancel.
    assign clr_hit   = we && busy[wa];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ZERO_REG && ra[i*AW +: AW] == '0)
                rdata[i*XLEN +: XLEN] = '0;
            else if (BYPASS && we && wa == ra[i*AW +: AW])
                rdata[i*XLEN +: XLEN] = wd;
            else
                rdata[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
        end
    end

    // Set beats clear on the same register; flush beats both.
    always_comb begin
        busy_nxt = busy;
        if (we)     busy_nxt[wa]     = 1'b0;
        if (set_en) busy_nxt[iss_rd] = 1'b1;
        if (flush)  busy_nxt         = '0;
        pending_nxt = pending + CW'(set_en) - CW'(clr_hit);
        if (flush)  pending_nxt      = '0;
    end

    // NOTE: storage is cleared by reset because a reset mid-operation must
    // leave every register reading zero, not just the scoreboard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy    <= '0;
            pending <= '0;
        end else begin
            if (wr_en) regs[wa] <= wd;
            busy    <= busy_nxt;
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_sb_regfile.sv
// Self-checking bench for sb_regfile: directed vector table, random traffic
// against a rule-level model, and an asynchronous mid-cycle reset sequence.
`timescale 1ns/1ps
module tb_sb_regfile;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rdata;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [NRD*AW-1:0]    iss_rs;
    logic                 iss_ready;
    logic                 flush;
    logic [NREG-1:0]      busy;
    logic [CW-1:0]        pending;

    sb_regfile dut (
        .clk       (clk),
        .rstn      (rstn),
        .ra        (ra),
        .rdata     (rdata),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs    (iss_rs),
        .iss_ready (iss_ready),
        .flush     (flush),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic        fl;
        logic        chk;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_rdy;
        logic [31:0] e_busy;
        logic [5:0]  e_pend;
    } vec_t;

    logic [31:0] m_regs [NREG];
    bit          m_busy [NREG];
    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        tab [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hazardous(input logic [4:0] r, input vec_t v);
        return m_busy[r] && !(v.we && v.wa == r);
    endfunction

    function automatic bit model_ready(input vec_t v);
        if (v.fl) return 1'b0;
        return !(hazardous(v.ird, v) || hazardous(v.rs0, v) || hazardous(v.rs1, v));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input vec_t v);
        if (a == 0) return 32'h0;
        if (v.we && v.wa == a) return v.wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] b = '0;
        for (int i = 0; i < NREG; i++) b[i] = m_busy[i];
        return b;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive_cycle(input vec_t v, input string tag);
        bit rdy;
        @(negedge clk);
        we        = v.we;
        wa        = v.wa;
        wd        = v.wd;
        ra        = {v.ra1, v.ra0};
        iss_valid = v.iv;
        iss_rd    = v.ird;
        iss_rs    = {v.rs1, v.rs0};
        flush     = v.fl;
        #1;
        rdy = model_ready(v);
        check({tag, " rdata0"},    64'(rdata[31:0]),  64'(model_read(v.ra0, v)));
        check({tag, " rdata1"},    64'(rdata[63:32]), 64'(model_read(v.ra1, v)));
        check({tag, " iss_ready"}, 64'(iss_ready),    64'(rdy));
        check({tag, " busy"},      64'(busy),         64'(model_busy_vec()));
        check({tag, " pending"},   64'(pending),      64'(model_count()));
        if (v.chk) begin
            check({tag, " tab rdata0"},    64'(rdata[31:0]),  64'(v.e_rd0));
            check({tag, " tab rdata1"},    64'(rdata[63:32]), 64'(v.e_rd1));
            check({tag, " tab iss_ready"}, 64'(iss_ready),    64'(v.e_rdy));
            check({tag, " tab busy"},      64'(busy),         64'(v.e_busy));
            check({tag, " tab pending"},   64'(pending),      64'(v.e_pend));
        end
        @(posedge clk);
        if (v.we) m_busy[v.wa] = 1'b0;
        if (v.iv && rdy && v.ird != 0) m_busy[v.ird] = 1'b1;
        if (v.fl) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        if (v.we && v.wa != 0) m_regs[v.wa] = v.wd;
    endtask

    initial begin
        vec_t v;
        model_reset();
        rstn = 1'b0; we = 0; wa = 0; wd = 0; ra = {5'd5, 5'd0};
        iss_valid = 0; iss_rd = 0; iss_rs = 0; flush = 0;

        //      we wa  wd            ra0 ra1 iv ird rs0 rs1 fl chk e_rd0         e_rd1         rdy e_busy     pend
        tab[0]  = '{1, 5,  32'hDEADBEEF, 5,  0,  0, 0,  0,  0,  0, 1, 32'hDEADBEEF, 32'h0,        1, 32'h0,     0};
        tab[1]  = '{1, 0,  32'h00001234, 5,  0,  0, 0,  0,  0,  0, 1, 32'hDEADBEEF, 32'h0,        1, 32'h0,     0};
        tab[2]  = '{0, 0,  32'h0,        0,  5,  1, 0,  0,  0,  0, 1, 32'h0,        32'hDEADBEEF, 1, 32'h0,     0};
        tab[3]  = '{0, 0,  32'h0,        0,  0,  1, 3,  0,  0,  0, 1, 32'h0,        32'h0,        1, 32'h0,     0};
        tab[4]  = '{0, 0,  32'h0,        3,  1,  1, 9,  3,  1,  0, 1, 32'h0,        32'h0,        0, 32'h8,     1};
        tab[5]  = '{1, 3,  32'h33,       3,  0,  1, 9,  3,  1,  0, 1, 32'h33,       32'h0,        1, 32'h8,     1};
        tab[6]  = '{1, 7,  32'h77,       3,  7,  1, 7,  0,  0,  0, 1, 32'h33,       32'h77,       1, 32'h200,   1};
        tab[7]  = '{1, 9,  32'h99,       7,  0,  0, 0,  0,  0,  0, 1, 32'h77,       32'h0,        1, 32'h280,   2};
        tab[8]  = '{1, 7,  32'h78,       9,  0,  0, 0,  0,  0,  0, 1, 32'h99,       32'h0,        1, 32'h80,    1};
        tab[9]  = '{0, 0,  32'h0,        7,  0,  1, 2,  0,  0,  0, 1, 32'h78,       32'h0,        1, 32'h0,     0};
        tab[10] = '{0, 0,  32'h0,        0,  0,  1, 4,  0,  0,  0, 1, 32'h0,        32'h0,        1, 32'h4,     1};
        tab[11] = '{0, 0,  32'h0,        0,  0,  1, 6,  0,  0,  0, 1, 32'h0,        32'h0,        1, 32'h14,    2};
        tab[12] = '{1, 10, 32'hA,        10, 0,  1, 8,  0,  0,  1, 1, 32'hA,        32'h0,        0, 32'h54,    3};
        tab[13] = '{0, 0,  32'h0,        10, 0,  0, 0,  0,  0,  0, 1, 32'hA,        32'h0,        1, 32'h0,     0};
        tab[14] = '{0, 0,  32'h0,        0,  0,  1, 11, 0,  0,  0, 1, 32'h0,        32'h0,        1, 32'h0,     0};
        tab[15] = '{1, 11, 32'hB,        11, 0,  1, 11, 0,  0,  0, 1, 32'hB,        32'h0,        1, 32'h800,   1};
        tab[16] = '{0, 0,  32'h0,        11, 0,  0, 0,  0,  0,  0, 1, 32'hB,        32'h0,        1, 32'h800,   1};

        #12;
        check("reset busy",    64'(busy),         64'h0);
        check("reset pending", 64'(pending),      64'h0);
        check("reset rdata1",  64'(rdata[63:32]), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 17; i++) drive_cycle(tab[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 400; n++) begin
            v = '{default: '0};
            v.we  = 1'($urandom_range(0, 1));
            v.wa  = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.ra0 = 5'($urandom_range(0, 9));
            v.ra1 = 5'($urandom_range(0, 9));
            v.iv  = ($urandom_range(0, 2) != 0);
            v.ird = 5'($urandom_range(0, 7));
            v.rs0 = 5'($urandom_range(0, 7));
            v.rs1 = 5'($urandom_range(0, 7));
            v.fl  = ($urandom_range(0, 15) == 0);
            drive_cycle(v, $sformatf("rnd%0d", n));
        end

        // Build pending=2 with known storage, then reset asynchronously mid-cycle.
        v = '{default: '0};
        v.fl = 1'b1; v.we = 1'b1; v.wa = 5'd12; v.wd = 32'hC0FFEE;
        drive_cycle(v, "pre_rst flush");
        v = '{default: '0};
        v.iv = 1'b1; v.ird = 5'd11;
        drive_cycle(v, "pre_rst iss11");
        v.ird = 5'd12;
        drive_cycle(v, "pre_rst iss12");
        #1;
        check("pre_rst pending", 64'(pending), 64'd2);
        we = 0; iss_valid = 0; flush = 0; ra = {5'd0, 5'd12};
        #1;
        check("pre_rst rdata0", 64'(rdata[31:0]), 64'hC0FFEE);
        rstn = 1'b0;
        #1;
        check("async rst busy",    64'(busy),        64'h0);
        check("async rst pending", 64'(pending),     64'h0);
        check("async rst rdata0",  64'(rdata[31:0]), 64'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        v = '{default: '0};
        v.iv = 1'b1; v.ird = 5'd11; v.rs0 = 5'd12; v.rs1 = 5'd11; v.ra0 = 5'd12;
        v.chk = 1'b1; v.e_rdy = 1'b1;
        drive_cycle(v, "post_rst issue");
        v = '{default: '0};
        v.chk = 1'b1; v.e_rdy = 1'b1; v.e_busy = 32'h800; v.e_pend = 6'd1;
        drive_cycle(v, "post_rst state");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
